// File: rtl/axis_pkt_rr_arbiter_pkg.sv
// Shared types and width helpers for the packet round-robin AXIS arbiter.
// Defines the FSM state encoding and the source-index width function.
package axis_pkt_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Width of a source index; a single-source arbiter still carries a 1-bit id.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_pkt_rr_arbiter_rr_grant_picker.sv
// Combinational rotating priority encoder: returns the first asserted request
// found when scanning upward from ptr, wrapping at src_n-1.
module rr_grant_picker
    import axis_pkt_rr_arbiter_pkg::*;
#(
    parameter int src_n = 2,
    parameter int id_w  = id_width(src_n)
) (
    input  logic [src_n-1:0] req,
    input  logic [id_w-1:0]  ptr,
    output logic [id_w-1:0]  gnt_idx,
    output logic             gnt_vld
);

    localparam logic [id_w:0] src_n_w = (id_w + 1)'(src_n);

    logic [id_w:0]   sum;
    logic [id_w-1:0] idx;

    // Walk from the farthest offset back to ptr so the nearest requester wins last.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = src_n - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (id_w + 1)'(k);
            if (sum >= src_n_w)
                sum = sum - src_n_w;
            idx = sum[id_w-1:0];
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin merge of src_n AXIS slaves onto one registered
// AXIS master; a grant is held from first beat through tlast.
module axis_pkt_rr_arbiter
    import axis_pkt_rr_arbiter_pkg::*;
#(
    parameter int src_n            = 2,
    parameter int data_width       = 32,
    parameter int user_width       = 1,
    parameter int simulation_delay = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [src_n*data_width-1:0]   s_axis_data,
    input  logic [src_n*data_width/8-1:0] s_axis_keep,
    input  logic [src_n*user_width-1:0]   s_axis_user,
    input  logic [src_n-1:0]              s_axis_last,
    input  logic [src_n-1:0]              s_axis_valid,
    output logic [src_n-1:0]              s_axis_ready,
    output logic [data_width-1:0]         m_axis_data,
    output logic [data_width/8-1:0]       m_axis_keep,
    output logic [user_width-1:0]         m_axis_user,
    output logic [id_width(src_n)-1:0]    m_axis_id,
    output logic                          m_axis_last,
    output logic                          m_axis_valid,
    input  logic                          m_axis_ready
);

    localparam int              id_w     = id_width(src_n);
    localparam int              keep_w   = data_width / 8;
    localparam logic [id_w-1:0] last_src = id_w'(src_n - 1);

    arb_state_t      state, state_nxt;
    logic [id_w-1:0] grant, grant_nxt;
    logic [id_w-1:0] prio_ptr, prio_ptr_nxt;
    logic [id_w-1:0] pick_idx;
    logic            pick_vld;
    logic            slot_free;
    logic            take;

    logic                  out_vld;
    logic [id_w-1:0]       out_id;
    logic [data_width-1:0] out_data;
    logic [keep_w-1:0]     out_keep;
    logic [user_width-1:0] out_user;
    logic                  out_last;

    rr_grant_picker #(
        .src_n (src_n),
        .id_w  (id_w)
    ) u_picker (
        .req     (s_axis_valid),
        .ptr     (prio_ptr),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    // The output register can accept a beat when empty or draining this cycle.
    assign slot_free = ~out_vld | m_axis_ready;
    assign take      = (state == BUSY) & s_axis_valid[grant] & slot_free;

    always_comb begin
        s_axis_ready = '0;
        if (state == BUSY)
            s_axis_ready[grant] = slot_free;
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        prio_ptr_nxt = prio_ptr;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = BUSY;
                    grant_nxt = pick_idx;
                end
            end
            BUSY: begin
                if (take && s_axis_last[grant]) begin
                    state_nxt    = IDLE;
                    prio_ptr_nxt = (grant == last_src) ? '0 : grant + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            prio_ptr <= '0;
            out_vld  <= 1'b0;
            out_id   <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            prio_ptr <= prio_ptr_nxt;
            if (take) begin
                out_vld <= 1'b1;
                out_id  <= grant;
            end else if (m_axis_ready) begin
                out_vld <= 1'b0;
            end
        end
    end

    // Payload registers carry no reset; out_vld qualifies them.
    always_ff @(posedge clk) begin
        if (take) begin
            out_data <= s_axis_data[grant*data_width +: data_width];
            out_keep <= s_axis_keep[grant*keep_w +: keep_w];
            out_user <= s_axis_user[grant*user_width +: user_width];
            out_last <= s_axis_last[grant];
        end
    end

    // simulation_delay only shifts simulated timing; this view is zero-delay.
    if (simulation_delay >= 0) begin : g_out
        assign m_axis_valid = out_vld;
        assign m_axis_id    = out_id;
        assign m_axis_data  = out_data;
        assign m_axis_keep  = out_keep;
        assign m_axis_user  = out_user;
        assign m_axis_last  = out_last;
    end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Self-checking bench for axis_pkt_rr_arbiter: a grant table plus sequences for
// throughput, late requesters, backpressure, mid-packet stall and reset.
module tb_axis_pkt_rr_arbiter;

    localparam int SRC_N = 4;
    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int UW    = 1;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [SRC_N*DW-1:0]   s_axis_data;
    logic [SRC_N*KW-1:0]   s_axis_keep;
    logic [SRC_N*UW-1:0]   s_axis_user;
    logic [SRC_N-1:0]      s_axis_last;
    logic [SRC_N-1:0]      s_axis_valid;
    logic [SRC_N-1:0]      s_axis_ready;
    logic [DW-1:0]         m_axis_data;
    logic [KW-1:0]         m_axis_keep;
    logic [UW-1:0]         m_axis_user;
    logic [IDW-1:0]        m_axis_id;
    logic                  m_axis_last;
    logic                  m_axis_valid;
    logic                  m_axis_ready;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic [UW-1:0]  user;
        logic           last;
    } beat_t;

    typedef struct {
        logic [SRC_N-1:0] req;
        logic [IDW-1:0]   exp_id;
    } vec_t;

    beat_t         exp_q[$];
    beat_t         obs_q[$];
    int            obs_cyc[$];
    logic [DW-1:0] src_data[SRC_N][32];
    logic          src_last[SRC_N][32];
    int            head[SRC_N];
    int            tail[SRC_N];
    logic [SRC_N-1:0] hold;
    logic          bp;
    int            nchk = 0;
    int            nerr = 0;
    int            ncyc = 0;
    vec_t          vt[8];

    axis_pkt_rr_arbiter #(
        .src_n            (SRC_N),
        .data_width       (DW),
        .user_width       (UW),
        .simulation_delay (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_data  (s_axis_data),
        .s_axis_keep  (s_axis_keep),
        .s_axis_user  (s_axis_user),
        .s_axis_last  (s_axis_last),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_keep  (m_axis_keep),
        .m_axis_user  (m_axis_user),
        .m_axis_id    (m_axis_id),
        .m_axis_last  (m_axis_last),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready)
    );

    always #5 clk = ~clk;

    // Output monitor: record every downstream handshake, sampled mid-cycle.
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (rst_n && m_axis_valid && m_axis_ready) begin
            obs_q.push_back('{id: m_axis_id, data: m_axis_data, keep: m_axis_keep,
                              user: m_axis_user, last: m_axis_last});
            obs_cyc.push_back(ncyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic beat_t mk(input logic [IDW-1:0] id, input logic [DW-1:0] d, input logic l);
        mk = '{id: id, data: d, keep: d[3:0], user: d[4], last: l};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < SRC_N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    task automatic push_pkt(input int src, input logic [DW-1:0] base, input int n);
        for (int b = 0; b < n; b++) begin
            src_data[src][tail[src]] = base + DW'(b);
            src_last[src][tail[src]] = (b == n - 1);
            tail[src]++;
        end
    endtask

    task automatic exp_pkt(input int src, input logic [DW-1:0] base, input int n);
        for (int b = 0; b < n; b++)
            exp_q.push_back(mk(IDW'(src), base + DW'(b), b == n - 1));
    endtask

    task automatic drive();
        for (int i = 0; i < SRC_N; i++) begin
            logic [DW-1:0] d;
            logic          have;
            have = (head[i] != tail[i]);
            d    = have ? src_data[i][head[i]] : '0;
            s_axis_valid[i]        = have && !hold[i];
            s_axis_last[i]         = have ? src_last[i][head[i]] : 1'b0;
            s_axis_data[i*DW +: DW] = d;
            s_axis_keep[i*KW +: KW] = d[3:0];
            s_axis_user[i]         = d[4];
        end
    endtask

    function automatic bit busy();
        busy = 1'b0;
        for (int i = 0; i < SRC_N; i++)
            if (head[i] != tail[i]) busy = 1'b1;
    endfunction

    // One clock: sample handshakes mid-cycle, then advance sources after the edge.
    task automatic step(output logic [SRC_N-1:0] hs);
        @(negedge clk);
        hs = s_axis_valid & s_axis_ready;
        if (m_axis_valid && !m_axis_ready)
            check("stall_ready", 64'(s_axis_ready), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < SRC_N; i++)
            if (hs[i]) head[i]++;
        m_axis_ready = bp ? ~m_axis_ready : 1'b1;
        drive();
    endtask

    task automatic run(input int maxc, input string name);
        logic [SRC_N-1:0] hs;
        int n;
        n = 0;
        while (busy() && n < maxc) begin
            step(hs);
            n++;
        end
        check({name, "_timeout"}, 64'(busy()), 64'd0);
        repeat (4) step(hs);
    endtask

    task automatic drain(input string name);
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check(name, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        check({name, "_leftover"}, 64'(obs_q.size() + exp_q.size()), 64'd0);
        obs_q.delete();
        exp_q.delete();
        obs_cyc.delete();
    endtask

    task automatic wait_hs(input int src, input int cnt, input string name);
        logic [SRC_N-1:0] hs;
        int n, seen;
        n = 0;
        seen = 0;
        while (seen < cnt && n < 30) begin
            step(hs);
            if (hs[src]) seen++;
            n++;
        end
        check(name, 64'(seen), 64'(cnt));
    endtask

    initial begin
        logic [SRC_N-1:0] hs;
        int n;

        vt[0] = '{req: 4'b1111, exp_id: 2'd0};
        vt[1] = '{req: 4'b1111, exp_id: 2'd1};
        vt[2] = '{req: 4'b0001, exp_id: 2'd0};
        vt[3] = '{req: 4'b1000, exp_id: 2'd3};
        vt[4] = '{req: 4'b0110, exp_id: 2'd1};
        vt[5] = '{req: 4'b0011, exp_id: 2'd0};
        vt[6] = '{req: 4'b0100, exp_id: 2'd2};
        vt[7] = '{req: 4'b1001, exp_id: 2'd3};

        hold = '0;
        bp = 1'b0;
        m_axis_ready = 1'b1;
        flush();
        drive();

        // Reset held with every source requesting.
        rst_n = 1'b0;
        for (int i = 0; i < SRC_N; i++) push_pkt(i, 32'hEE, 1);
        drive();
        repeat (3) step(hs);
        check("rst_m_valid", 64'(m_axis_valid), 64'd0);
        check("rst_s_ready", 64'(s_axis_ready), 64'd0);
        check("rst_m_id", 64'(m_axis_id), 64'd0);
        flush();
        drive();
        rst_n = 1'b1;

        // Grant table of single-beat packets; losers are withdrawn after each grant.
        for (int v = 0; v < 8; v++) begin
            flush();
            for (int i = 0; i < SRC_N; i++)
                if (vt[v].req[i]) push_pkt(i, 32'hC000_0000 | DW'(v << 8) | DW'(i), 1);
            exp_q.push_back(mk(vt[v].exp_id, 32'hC000_0000 | DW'(v << 8) | DW'(vt[v].exp_id), 1'b1));
            drive();
            hs = '0;
            n = 0;
            while (hs == '0 && n < 10) begin
                step(hs);
                n++;
            end
            check("tbl_grant", 64'(hs), 64'(4'b0001 << vt[v].exp_id));
            flush();
            drive();
            repeat (2) step(hs);
            drain("tbl_beat");
        end

        // All sources busy with 3-beat packets: order 0,1,2,3,0,1 with one bubble.
        flush();
        for (int s = 0; s < SRC_N; s++) push_pkt(s, 32'hB000_0000 | DW'(s << 8), 3);
        push_pkt(0, 32'hB000_0010, 3);
        push_pkt(1, 32'hB000_0110, 3);
        for (int s = 0; s < SRC_N; s++) exp_pkt(s, 32'hB000_0000 | DW'(s << 8), 3);
        exp_pkt(0, 32'hB000_0010, 3);
        exp_pkt(1, 32'hB000_0110, 3);
        drive();
        run(100, "rr");
        for (int k = 1; k < obs_cyc.size(); k++)
            check("rr_gap", 64'(obs_cyc[k] - obs_cyc[k-1]), obs_q[k-1].last ? 64'd2 : 64'd1);
        drain("rr_beat");

        // src1 shows up during src0's packet and must wait for its tlast.
        flush();
        push_pkt(0, 32'h0000_00A0, 4);
        exp_pkt(0, 32'h0000_00A0, 4);
        exp_pkt(1, 32'h0000_00B0, 2);
        drive();
        wait_hs(0, 1, "late_first_beat");
        push_pkt(1, 32'h0000_00B0, 2);
        drive();
        run(50, "late");
        drain("late_beat");

        // Downstream ready toggles every cycle across an 8-beat packet.
        flush();
        bp = 1'b1;
        push_pkt(2, 32'h0000_0000, 8);
        exp_pkt(2, 32'h0000_0000, 8);
        drive();
        run(100, "bp");
        bp = 1'b0;
        repeat (3) step(hs);
        drain("bp_beat");

        // Granted src2 goes quiet mid-packet while src0 waits.
        flush();
        push_pkt(2, 32'h0000_00D0, 4);
        exp_pkt(2, 32'h0000_00D0, 4);
        exp_pkt(0, 32'h0000_00E0, 1);
        drive();
        wait_hs(2, 2, "stall_lead");
        hold[2] = 1'b1;
        push_pkt(0, 32'h0000_00E0, 1);
        drive();
        for (int c = 0; c < 5; c++) begin
            step(hs);
            check("stall_grant", 64'(s_axis_ready), 64'(4'b0100));
        end
        hold = '0;
        drive();
        run(50, "stall");
        drain("stall_beat");

        // Reset lands while beat 2 of a 4-beat packet sits in the output register.
        flush();
        push_pkt(3, 32'h0000_00F0, 4);
        exp_q.push_back(mk(2'd3, 32'h0000_00F0, 1'b0));
        drive();
        wait_hs(3, 2, "mid_rst_lead");
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", 64'(m_axis_valid), 64'd0);
        check("mid_rst_s_ready", 64'(s_axis_ready), 64'd0);
        check("mid_rst_m_id", 64'(m_axis_id), 64'd0);
        flush();
        drive();
        step(hs);
        rst_n = 1'b1;
        push_pkt(1, 32'h0000_0011, 1);
        push_pkt(0, 32'h0000_0010, 1);
        exp_pkt(0, 32'h0000_0010, 1);
        exp_pkt(1, 32'h0000_0011, 1);
        drive();
        run(50, "post_rst");
        drain("post_rst_beat");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
